// File: rtl/sqrt_operand_ctrl.sv
// Operand unpack/classify front end and result pack back end for the
// iterative significand square-root core, driven by a four-state controller.
module sqrt_operand_ctrl #(
    parameter int E_DW        = 8,
    parameter int F_DW        = 7,
    parameter int BIAS        = 127,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start_i,
    input  logic [E_DW+F_DW:0]     op_i,
    output logic                   busy_o,
    output logic                   doSqrt_o,
    output logic                   special_case_o,
    output logic [F_DW:0]          s_o,
    output logic                   is_exp_odd_o,
    input  logic                   core_valid_i,
    input  logic [F_DW:0]          core_res_i,
    output logic                   valid_o,
    output logic [E_DW+F_DW:0]     res_o,
    output logic                   invalid_o,
    output logic                   timeout_o
);

    localparam int W  = 1 + E_DW + F_DW;
    localparam int CW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    localparam logic [W-1:0]  QNAN   = {1'b0, {E_DW{1'b1}}, 1'b1, {(F_DW-1){1'b0}}};
    localparam logic [W-1:0]  PINF   = {1'b0, {E_DW{1'b1}}, {F_DW{1'b0}}};
    localparam logic [E_DW:0] BIAS_V = (E_DW+1)'(BIAS);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LAUNCH = 2'd1,
        S_WAIT   = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    typedef struct packed {
        logic         special;
        logic         invalid;
        logic [W-1:0] res;
    } cls_t;

    // Denormals are flushed to zero, so exp==0 is checked first and keeps the sign.
    function automatic cls_t classify(input logic [W-1:0] op);
        cls_t c;
        logic            sgn;
        logic [E_DW-1:0] ex;
        logic [F_DW-1:0] fr;
        sgn = op[W-1];
        ex  = op[E_DW+F_DW-1:F_DW];
        fr  = op[F_DW-1:0];
        c.special = 1'b1;
        c.invalid = 1'b0;
        c.res     = {W{1'b0}};
        if (ex == {E_DW{1'b0}}) begin
            c.res = {sgn, {(W-1){1'b0}}};
        end else if ((ex == {E_DW{1'b1}}) && (fr != {F_DW{1'b0}})) begin
            c.res     = QNAN;
            c.invalid = 1'b1;
        end else if ((ex == {E_DW{1'b1}}) && !sgn) begin
            c.res = PINF;
        end else if (sgn) begin
            c.res     = QNAN;
            c.invalid = 1'b1;
        end else begin
            c.special = 1'b0;
        end
        return c;
    endfunction

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            busy_q, busy_d;
    logic            do_sqrt_q, do_sqrt_d;
    logic            special_q, special_d;
    logic [F_DW:0]   s_q, s_d;
    logic            odd_q, odd_d;
    logic            is_special_q, is_special_d;
    logic            spec_inv_q, spec_inv_d;
    logic [W-1:0]    spec_res_q, spec_res_d;
    logic [E_DW-1:0] res_exp_q, res_exp_d;
    logic            valid_q, valid_d;
    logic [W-1:0]    res_q, res_d;
    logic            invalid_q, invalid_d;
    logic            timeout_q, timeout_d;

    cls_t            cls_s;
    logic [E_DW-1:0] op_exp_s;
    logic            op_odd_s;
    logic [E_DW:0]   exp_sum_s;
    logic            unused_hidden_s;

    assign unused_hidden_s = core_res_i[F_DW];

    // Next-state and next-output computation for the whole controller.
    always_comb begin
        cls_s     = classify(op_i);
        op_exp_s  = op_i[E_DW+F_DW-1:F_DW];
        op_odd_s  = op_exp_s[0] ^ BIAS_V[0];
        // One guard bit keeps exp+BIAS from wrapping before the halving.
        exp_sum_s = {1'b0, op_exp_s} + BIAS_V - {{E_DW{1'b0}}, op_odd_s};

        state_d      = state_q;
        cnt_d        = cnt_q;
        busy_d       = busy_q;
        do_sqrt_d    = 1'b0;
        special_d    = 1'b0;
        s_d          = s_q;
        odd_d        = odd_q;
        is_special_d = is_special_q;
        spec_inv_d   = spec_inv_q;
        spec_res_d   = spec_res_q;
        res_exp_d    = res_exp_q;
        valid_d      = 1'b0;
        res_d        = res_q;
        invalid_d    = invalid_q;
        timeout_d    = timeout_q;

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d      = S_LAUNCH;
                    busy_d       = 1'b1;
                    do_sqrt_d    = ~cls_s.special;
                    special_d    = cls_s.special;
                    s_d          = {1'b1, op_i[F_DW-1:0]};
                    odd_d        = op_odd_s;
                    is_special_d = cls_s.special;
                    spec_inv_d   = cls_s.invalid;
                    spec_res_d   = cls_s.res;
                    res_exp_d    = exp_sum_s[E_DW:1];
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_LAUNCH: begin
                state_d = S_WAIT;
                cnt_d   = {CW{1'b0}};
            end
            S_WAIT: begin
                if (core_valid_i) begin
                    state_d   = S_DONE;
                    valid_d   = 1'b1;
                    res_d     = is_special_q ? spec_res_q
                                             : {1'b0, res_exp_q, core_res_i[F_DW-1:0]};
                    invalid_d = spec_inv_q;
                    timeout_d = 1'b0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d   = S_DONE;
                    valid_d   = 1'b1;
                    res_d     = QNAN;
                    invalid_d = 1'b0;
                    timeout_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and registered-output update with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= {CW{1'b0}};
            busy_q       <= 1'b0;
            do_sqrt_q    <= 1'b0;
            special_q    <= 1'b0;
            s_q          <= {(F_DW+1){1'b0}};
            odd_q        <= 1'b0;
            is_special_q <= 1'b0;
            spec_inv_q   <= 1'b0;
            spec_res_q   <= {W{1'b0}};
            res_exp_q    <= {E_DW{1'b0}};
            valid_q      <= 1'b0;
            res_q        <= {W{1'b0}};
            invalid_q    <= 1'b0;
            timeout_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            busy_q       <= busy_d;
            do_sqrt_q    <= do_sqrt_d;
            special_q    <= special_d;
            s_q          <= s_d;
            odd_q        <= odd_d;
            is_special_q <= is_special_d;
            spec_inv_q   <= spec_inv_d;
            spec_res_q   <= spec_res_d;
            res_exp_q    <= res_exp_d;
            valid_q      <= valid_d;
            res_q        <= res_d;
            invalid_q    <= invalid_d;
            timeout_q    <= timeout_d;
        end
    end

    assign busy_o         = busy_q;
    assign doSqrt_o       = do_sqrt_q;
    assign special_case_o = special_q;
    assign s_o            = s_q;
    assign is_exp_odd_o   = odd_q;
    assign valid_o        = valid_q;
    assign res_o          = res_q;
    assign invalid_o      = invalid_q;
    assign timeout_o      = timeout_q;

endmodule

// File: tb/tb_sqrt_operand_ctrl.sv
// Randomized bench for sqrt_operand_ctrl against a value-level float model.
module tb_sqrt_operand_ctrl;

    localparam int TMO = 64;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_i;
    logic [15:0] op_i;
    logic        busy_o, doSqrt_o, special_case_o, is_exp_odd_o;
    logic [7:0]  s_o;
    logic        core_valid_i;
    logic [7:0]  core_res_i;
    logic        valid_o, invalid_o, timeout_o;
    logic [15:0] res_o;

    int n_checks = 0;
    int n_fail   = 0;

    sqrt_operand_ctrl #(.E_DW(8), .F_DW(7), .BIAS(127), .TIMEOUT_CYC(TMO)) dut (
        .clk(clk), .rst(rst), .start_i(start_i), .op_i(op_i),
        .busy_o(busy_o), .doSqrt_o(doSqrt_o), .special_case_o(special_case_o),
        .s_o(s_o), .is_exp_odd_o(is_exp_odd_o),
        .core_valid_i(core_valid_i), .core_res_i(core_res_i),
        .valid_o(valid_o), .res_o(res_o), .invalid_o(invalid_o), .timeout_o(timeout_o)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // sqrt(m * 2^e) = sqrt(m * 2^(e mod 2)) * 2^floor(e/2); special values per IEEE-like rules.
    function automatic void model(input logic [15:0] op, input logic [7:0] cres, input bit tmo,
                                  output logic [15:0] r, output bit inv, output bit spec,
                                  output bit odd);
        int ex, e, h;
        bit sgn;
        sgn  = op[15];
        ex   = int'(op[14:7]);
        e    = ex - 127;
        odd  = (e & 1) != 0;
        spec = 1'b1;
        inv  = 1'b0;
        if (ex == 0) begin
            r = {sgn, 15'h0000};
        end else if (ex == 255 && op[6:0] != 7'd0) begin
            r = 16'h7FC0; inv = 1'b1;
        end else if (ex == 255 && !sgn) begin
            r = 16'h7F80;
        end else if (sgn) begin
            r = 16'h7FC0; inv = 1'b1;
        end else begin
            spec = 1'b0;
            h = (e - (e & 1)) / 2;
            r = {1'b0, 8'(h + 127), cres[6:0]};
        end
        if (tmo) begin
            r = 16'h7FC0; inv = 1'b0;
        end
    endfunction

    // c: cycles from the launch cycle to the core_valid_i cycle; poke: stray start during WAIT.
    task automatic run_op(input logic [15:0] op, input int c, input logic [7:0] cres, input bit poke);
        logic [15:0] er;
        bit inv, spec, odd, tmo, got_v;
        int exp_cyc;
        tmo     = !(c >= 1 && c <= TMO);
        exp_cyc = tmo ? TMO + 3 : c + 3;
        model(op, cres, tmo, er, inv, spec, odd);
        @(negedge clk);
        start_i = 1'b1; op_i = op; core_valid_i = 1'b0;
        got_v = 1'b0;
        for (int cyc = 2; cyc <= 100 && !got_v; cyc++) begin
            @(negedge clk);
            start_i = 1'b0;
            op_i    = 16'($urandom);
            if (cyc == 2) begin
                check_eq("launch_busy", {31'd0, busy_o}, 32'd1);
                check_eq("launch_pulses", {30'd0, doSqrt_o, special_case_o}, {30'd0, !spec, spec});
                check_eq("s_o", {24'd0, s_o}, {24'd0, 1'b1, op[6:0]});
                check_eq("exp_odd", {31'd0, is_exp_odd_o}, {31'd0, odd});
            end else if (cyc == 3) begin
                check_eq("pulse_single", {30'd0, doSqrt_o, special_case_o}, 32'd0);
            end
            if (valid_o) begin
                got_v = 1'b1;
                check_eq("latency", 32'(cyc), 32'(exp_cyc));
                check_eq("res_o", {16'd0, res_o}, {16'd0, er});
                check_eq("flags", {29'd0, invalid_o, timeout_o, busy_o}, {29'd0, inv, tmo, 1'b1});
                check_eq("s_hold", {24'd0, s_o}, {24'd0, 1'b1, op[6:0]});
            end
            core_valid_i = (cyc == 2 + c);
            core_res_i   = (cyc == 2 + c) ? cres : 8'($urandom);
            if (poke && cyc == 6 && !got_v) begin
                start_i = 1'b1; op_i = 16'h3F80;
            end
        end
        if (!got_v) check_eq("valid_seen", 32'd0, 32'd1);
        core_valid_i = 1'b0;
        @(negedge clk);
        check_eq("post_idle", {30'd0, valid_o, busy_o}, 32'd0);
        check_eq("res_held", {16'd0, res_o}, {16'd0, er});
    endtask

    initial begin
        logic [15:0] rop;
        logic [7:0]  rc;
        bit          saw_v;
        rst = 1'b1; start_i = 1'b0; op_i = 16'h0; core_valid_i = 1'b0; core_res_i = 8'h0;
        repeat (3) @(negedge clk);
        check_eq("reset_outs", {1'b0, busy_o, doSqrt_o, special_case_o, s_o, is_exp_odd_o,
                                valid_o, res_o, invalid_o, timeout_o}, 32'd0);
        rst = 1'b0;

        run_op(16'h3F80, 2, 8'h80, 1'b0);
        run_op(16'h4080, 3, 8'h80, 1'b0);
        run_op(16'h4000, 1, 8'hB5, 1'b0);
        run_op(16'hC080, 4, 8'hC3, 1'b0);
        run_op(16'h7F80, 2, 8'hAA, 1'b0);
        run_op(16'h8000, 5, 8'h91, 1'b0);
        run_op(16'h0001, 2, 8'hFF, 1'b0);
        run_op(16'h7FC1, 3, 8'h80, 1'b0);
        run_op(16'h3F80, 1000, 8'h80, 1'b1);
        run_op(16'h4100, 0, 8'h9A, 1'b0);
        run_op(16'h3E00, TMO, 8'hB5, 1'b0);
        run_op(16'h0080, 10, 8'hE1, 1'b1);
        run_op(16'h7F7F, 1, 8'hFF, 1'b0);

        for (int i = 0; i < 40; i++) begin
            rop = 16'($urandom);
            case ($urandom_range(0, 5))
                0:       rop[14:7] = 8'h00;
                1:       rop[14:7] = 8'hFF;
                default: rop[14:7] = rop[14:7];
            endcase
            rc = {1'b1, 7'($urandom)};
            run_op(rop, int'($urandom_range(1, 12)), rc, 1'b0);
        end

        // Reset during WAIT: everything clears and the pending result never appears.
        @(negedge clk);
        start_i = 1'b1; op_i = 16'h4080;
        repeat (3) begin
            @(negedge clk);
            start_i = 1'b0;
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_eq("midrst_outs", {1'b0, busy_o, doSqrt_o, special_case_o, s_o, is_exp_odd_o,
                                 valid_o, res_o, invalid_o, timeout_o}, 32'd0);
        saw_v = 1'b0;
        for (int k = 0; k < TMO + 10; k++) begin
            core_valid_i = (k == 2);
            core_res_i   = 8'hB5;
            @(negedge clk);
            if (valid_o || busy_o) saw_v = 1'b1;
        end
        core_valid_i = 1'b0;
        check_eq("midrst_silent", {31'd0, saw_v}, 32'd0);
        run_op(16'h4000, 2, 8'hB5, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
